// File: rtl/jtag_cmd_pkg.sv
// Shared command constants and FSM state encoding for the JTAG command engine.
package jtag_cmd_pkg;

    localparam logic [7:0] CMD_RDBK_BASE   = 8'h80;
    localparam logic [7:0] CMD_STROBE_BASE = 8'hF0;
    localparam logic [7:0] CMD_REPORT      = 8'hFE;
    localparam logic [7:0] CMD_RESET       = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        RDBK,
        HDR,
        SEND
    } state_e;

endpackage

// File: rtl/jtag_report_seq.sv
// Status report sequencer: coherent shadow snapshot, word index and header word.
module jtag_report_seq
    import jtag_cmd_pkg::*;
#(
    parameter int unsigned NUM_STATUS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_snap,
    input  logic                    i_adv,
    input  logic                    i_clear,
    input  logic [32*NUM_STATUS-1:0] i_status,
    output logic [31:0]             o_hdr_c,
    output logic [31:0]             o_word_c,
    output logic [31:0]             o_next_word_c,
    output logic                    o_last_c
);

    logic [31:0] r_shadow [NUM_STATUS];
    logic [7:0]  r_idx;
    logic [7:0]  w_idx_p1;

    assign w_idx_p1 = r_idx + 8'd1;
    assign o_last_c = (r_idx == 8'(NUM_STATUS - 1));
    assign o_hdr_c  = {CMD_REPORT, 8'(NUM_STATUS), 16'h0000};

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_idx <= 8'd0;
            for (int k = 0; k < NUM_STATUS; k++) r_shadow[k] <= 32'd0;
        end else if (i_snap) begin
            r_idx <= 8'd0;
            for (int k = 0; k < NUM_STATUS; k++) r_shadow[k] <= i_status[32*k +: 32];
        end else if (i_adv) begin
            r_idx <= o_last_c ? 8'd0 : w_idx_p1;
        end
    end

    // Current and next shadow word, muxed by compare to avoid index-width mismatch.
    always_comb begin
        o_word_c      = 32'd0;
        o_next_word_c = 32'd0;
        for (int k = 0; k < NUM_STATUS; k++) begin
            if (r_idx == 8'(k))    o_word_c      = r_shadow[k];
            if (w_idx_p1 == 8'(k)) o_next_word_c = r_shadow[k];
        end
    end

endmodule

// File: rtl/jtag_cmd_regbank.sv
// Host command decoder: control register bank, strobes, readback and status reports.
module jtag_cmd_regbank
    import jtag_cmd_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned REG_WIDTH  = 24,
    parameter int unsigned NUM_STATUS = 2,
    parameter logic [23:0] RESET_VAL  = 24'd0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   jtag_q,
    input  logic                          jtag_ack,
    output logic [31:0]                   jtag_d,
    output logic                          jtag_req,
    output logic                          jtag_wr,
    input  logic [32*NUM_STATUS-1:0]      status_i,
    output logic [REG_WIDTH*NUM_REGS-1:0] regs_o,
    output logic [7:0]                    strobe_o,
    output logic                          soft_reset_o
);

    localparam logic [REG_WIDTH-1:0] RST_V = RESET_VAL[REG_WIDTH-1:0];

    logic [REG_WIDTH-1:0] r_regs [NUM_REGS];
    state_e               r_state;
    logic [31:0]          r_jtag_d;
    logic                 r_jtag_wr;
    logic                 r_jtag_req;
    logic [7:0]           r_strobe;
    logic                 r_soft;

    state_e      w_state_n;
    logic [31:0] w_d_n;
    logic        w_wr_n;
    logic        w_snap;
    logic        w_adv;
    logic        w_rx;
    logic        w_soft;
    logic        w_is_strobe;
    logic [7:0]  w_cmd;
    logic        w_rd_valid;
    logic [31:0] w_rd_word;
    logic [31:0] w_hdr;
    logic [31:0] w_word;
    logic [31:0] w_next_word;
    logic        w_last;

    assign w_rx        = jtag_ack && !r_jtag_wr;
    assign w_cmd       = jtag_q[31:24];
    assign w_soft      = w_rx && (w_cmd == CMD_RESET);
    assign w_is_strobe = (w_cmd[7:3] == CMD_STROBE_BASE[7:3]);

    jtag_report_seq #(.NUM_STATUS(NUM_STATUS)) u_seq (
        .clk           (clk),
        .reset         (reset),
        .i_snap        (w_snap),
        .i_adv         (w_adv),
        .i_clear       (w_soft),
        .i_status      (status_i),
        .o_hdr_c       (w_hdr),
        .o_word_c      (w_word),
        .o_next_word_c (w_next_word),
        .o_last_c      (w_last)
    );

    // Readback decode: valid only for an in-range register index.
    always_comb begin
        w_rd_valid = 1'b0;
        w_rd_word  = 32'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cmd == (CMD_RDBK_BASE + 8'(i))) begin
                w_rd_valid = 1'b1;
                w_rd_word  = {w_cmd, 24'(r_regs[i])};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_soft) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RST_V;
        end else if (w_rx) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (w_cmd == 8'(i)) r_regs[i] <= jtag_q[REG_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_strobe   <= 8'd0;
            r_soft     <= 1'b0;
            r_jtag_req <= 1'b0;
        end else begin
            r_strobe   <= (w_rx && w_is_strobe) ? (8'd1 << w_cmd[2:0]) : 8'd0;
            r_soft     <= w_soft;
            r_jtag_req <= !jtag_ack;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_jtag_d  <= 32'd0;
            r_jtag_wr <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_jtag_d  <= w_d_n;
            r_jtag_wr <= w_wr_n;
        end
    end

    // Next state and next send word; jtag_d/jtag_wr only move on ack or leaving IDLE.
    always_comb begin
        w_state_n = r_state;
        w_d_n     = r_jtag_d;
        w_wr_n    = r_jtag_wr;
        w_snap    = 1'b0;
        w_adv     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rx && (w_cmd == CMD_REPORT)) begin
                    w_state_n = HDR;
                    w_d_n     = w_hdr;
                    w_wr_n    = 1'b1;
                    w_snap    = 1'b1;
                end else if (w_rx && w_rd_valid) begin
                    w_state_n = RDBK;
                    w_d_n     = w_rd_word;
                    w_wr_n    = 1'b1;
                end
            end
            RDBK: begin
                if (jtag_ack) begin
                    w_state_n = IDLE;
                    w_wr_n    = 1'b0;
                end
            end
            HDR: begin
                if (jtag_ack) begin
                    w_state_n = SEND;
                    w_d_n     = w_word;
                end
            end
            SEND: begin
                if (jtag_ack) begin
                    w_adv = 1'b1;
                    if (w_last) begin
                        w_state_n = IDLE;
                        w_wr_n    = 1'b0;
                    end else begin
                        w_d_n = w_next_word;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
                w_wr_n    = 1'b0;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        assign regs_o[REG_WIDTH*gi +: REG_WIDTH] = r_regs[gi];
    end

    assign jtag_d       = r_jtag_d;
    assign jtag_wr      = r_jtag_wr;
    assign jtag_req     = r_jtag_req;
    assign strobe_o     = r_strobe;
    assign soft_reset_o = r_soft;

endmodule

// File: tb/tb_jtag_cmd_regbank.sv
// Directed bench for jtag_cmd_regbank with default parameters (4 x 24-bit regs, 2 status words).
module tb_jtag_cmd_regbank;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] jtag_q;
    logic        jtag_ack;
    logic [31:0] jtag_d;
    logic        jtag_req;
    logic        jtag_wr;
    logic [63:0] status_i;
    logic [95:0] regs_o;
    logic [7:0]  strobe_o;
    logic        soft_reset_o;

    int n_total = 0;
    int n_pass  = 0;

    jtag_cmd_regbank dut (
        .clk          (clk),
        .reset        (reset),
        .jtag_q       (jtag_q),
        .jtag_ack     (jtag_ack),
        .jtag_d       (jtag_d),
        .jtag_req     (jtag_req),
        .jtag_wr      (jtag_wr),
        .status_i     (status_i),
        .regs_o       (regs_o),
        .strobe_o     (strobe_o),
        .soft_reset_o (soft_reset_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx(input logic [31:0] word);
        jtag_q   = word;
        jtag_ack = 1'b1;
        tick();
        jtag_ack = 1'b0;
    endtask

    task automatic ack();
        jtag_ack = 1'b1;
        tick();
        jtag_ack = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset    = 1'b1;
        jtag_q   = 32'd0;
        jtag_ack = 1'b0;
        status_i = 64'h11111111_22222222;
        tick();
        tick();
        chk("rst_req",   96'(jtag_req), 96'(1'b0));
        chk("rst_wr",    96'(jtag_wr), 96'(1'b0));
        chk("rst_d",     96'(jtag_d), 96'(32'd0));
        chk("rst_strb",  96'(strobe_o), 96'(8'd0));
        chk("rst_soft",  96'(soft_reset_o), 96'(1'b0));
        chk("rst_regs",  regs_o, 96'd0);

        reset = 1'b0;
        tick();
        chk("req_idle", 96'(jtag_req), 96'(1'b1));

        // Bank write
        rx(32'h02ABCDEF);
        chk("wr_reg2",   regs_o, {24'h0, 24'hABCDEF, 24'h0, 24'h0});
        chk("req_ack",   96'(jtag_req), 96'(1'b0));
        chk("wr_nosend", 96'(jtag_wr), 96'(1'b0));

        // Readback holds until consumed
        rx(32'h82000000);
        chk("rb_wr", 96'(jtag_wr), 96'(1'b1));
        chk("rb_d",  96'(jtag_d), 96'(32'h82ABCDEF));
        tick();
        tick();
        chk("rb_hold", 96'(jtag_d), 96'(32'h82ABCDEF));
        ack();
        chk("rb_done", 96'(jtag_wr), 96'(1'b0));

        // Report with snapshot coherence
        rx(32'hFE000000);
        status_i = 64'hDEADBEEF_CAFEF00D;
        chk("rep_wr",  96'(jtag_wr), 96'(1'b1));
        chk("rep_hdr", 96'(jtag_d), 96'(32'hFE020000));
        ack();
        chk("rep_w0", 96'(jtag_d), 96'(32'h22222222));
        ack();
        chk("rep_w1", 96'(jtag_d), 96'(32'h11111111));
        chk("rep_w1_wr", 96'(jtag_wr), 96'(1'b1));
        ack();
        chk("rep_end", 96'(jtag_wr), 96'(1'b0));

        // Strobe: one cycle only
        rx(32'hF3000000);
        chk("strb_on", 96'(strobe_o), 96'(8'h08));
        tick();
        chk("strb_off", 96'(strobe_o), 96'(8'h00));

        // Soft reset clears the bank
        rx(32'h01123456);
        chk("wr_reg1", regs_o, {24'h0, 24'hABCDEF, 24'h123456, 24'h0});
        rx(32'hFF000000);
        chk("soft_on",   96'(soft_reset_o), 96'(1'b1));
        chk("soft_regs", regs_o, 96'd0);
        chk("soft_strb", 96'(strobe_o), 96'(8'h00));
        tick();
        chk("soft_off", 96'(soft_reset_o), 96'(1'b0));

        // Out-of-range commands and the highest valid index
        rx(32'h03FFFFFF);
        chk("wr_reg3", regs_o, {24'hFFFFFF, 72'h0});
        rx(32'h07123456);
        chk("oor_wr_regs", regs_o, {24'hFFFFFF, 72'h0});
        chk("oor_wr_wr",   96'(jtag_wr), 96'(1'b0));
        rx(32'h85000000);
        chk("oor_rb_wr", 96'(jtag_wr), 96'(1'b0));
        tick();
        chk("oor_rb_wr2", 96'(jtag_wr), 96'(1'b0));
        rx(32'h83000000);
        chk("rb3_d", 96'(jtag_d), 96'(32'h83FFFFFF));
        ack();
        chk("rb3_done", 96'(jtag_wr), 96'(1'b0));

        // Reset in the middle of a report
        rx(32'hFE000000);
        chk("mid_hdr", 96'(jtag_d), 96'(32'hFE020000));
        ack();
        chk("mid_w0", 96'(jtag_d), 96'(32'hCAFEF00D));
        reset = 1'b1;
        tick();
        chk("mid_wr",  96'(jtag_wr), 96'(1'b0));
        chk("mid_req", 96'(jtag_req), 96'(1'b0));
        chk("mid_regs", regs_o, 96'd0);
        reset = 1'b0;
        status_i = 64'h33333333_44444444;
        tick();
        rx(32'hFE000000);
        chk("re_hdr", 96'(jtag_d), 96'(32'hFE020000));
        ack();
        chk("re_w0", 96'(jtag_d), 96'(32'h44444444));
        ack();
        chk("re_w1", 96'(jtag_d), 96'(32'h33333333));
        ack();
        chk("re_end", 96'(jtag_wr), 96'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jtag_cmd_regbank.md
# jtag_cmd_regbank

Parametrised host-control engine that sits between the JTAG debug bridge and the rest of the design. It decodes 32-bit command words from the host into a bank of N writable control registers and a set of one-cycle strobes. It also returns data to the host: single-register readback, or a coherent multi-word status report with a header. It is the generalised successor to the fixed per-demo command decoders: register count, register width and status-word count are parameters, and readback is added.

## Interface
- `NUM_REGS`, default 4: number of control registers, 1..64.
- `REG_WIDTH`, default 24: width of each control register, 1..24.
- `NUM_STATUS`, default 2: number of 32-bit status words in a report, 1..255.
- `RESET_VAL`, default 0: value loaded into every control register on reset (low `REG_WIDTH` bits).
- `clk`  in  1  system clock; the block uses one clock only.
- `reset`  in  1  synchronous, active-high reset.
- `jtag_q`  in  32  word received from the bridge.
- `jtag_ack`  in  1  one-cycle transfer-complete pulse from the bridge.
- `jtag_d`  out  32  word to send to the bridge.
- `jtag_req`  out  1  transfer request to the bridge.
- `jtag_wr`  out  1  1 = send `jtag_d`, 0 = receive.
- `status_i`  in  32*NUM_STATUS  status words; word k is at bits [32k+31:32k].
- `regs_o`  out  REG_WIDTH*NUM_REGS  control registers; register i is at bits [REG_WIDTH*i +: REG_WIDTH].
- `strobe_o`  out  8  user strobes, each a one-cycle pulse.
- `soft_reset_o`  out  1  one-cycle soft-reset pulse to the rest of the design.

## Operation
- **Bridge handshake:**
  - `jtag_req` is registered as `!jtag_ack`.
  - On an `jtag_ack` cycle, `jtag_wr` identifies the transfer: wr=0 means `jtag_q` holds a received word; wr=1 means `jtag_d` has been consumed.
  - `jtag_d` and `jtag_wr` change only on a cycle where `jtag_ack` is 1 or the FSM leaves IDLE.
- **Command byte:** `jtag_q[31:24]` when `jtag_ack && !jtag_wr`.
  - 0x00..NUM_REGS-1: register[cmd] <= `jtag_q[REG_WIDTH-1:0]`.
  - 0x80+i, with i < NUM_REGS: readback. Send one word {8'h80+i, register i zero-extended to 24 bits}.
  - 0xF0..0xF7: pulse `strobe_o[cmd-0xF0]`.
  - 0xFE: status report. All `NUM_STATUS` words are snapshotted into a shadow array in the same cycle. The block then sends the header {8'hFE, 8'(NUM_STATUS), 16'h0000}, followed by shadow words 0..NUM_STATUS-1.
  - 0xFF: pulse `soft_reset_o`, and every register returns to `RESET_VAL`.
  - Any other value, including an out-of-range index, is ignored. Nothing is sent and no register changes.
- **FSM:**
  - IDLE: wr=0. Leaves to HDR on 0xFE, or to RDBK on a valid 0x80+i.
  - RDBK: wr=1, d=readback word. Returns to IDLE on ack.
  - HDR: wr=1, d=header. Moves to SEND on ack, with idx=0.
  - SEND: wr=1, d=shadow[idx]. On ack, idx increments; on the ack where idx=NUM_STATUS-1, the FSM returns to IDLE.
- **Shadow coherence:** changes on `status_i` during a report do not affect the words being sent.

## Timing
- **Reset values:** `jtag_req`=0, `jtag_wr`=0, `jtag_d`=0, `strobe_o`=0, `soft_reset_o`=0, every register = `RESET_VAL`, FSM = IDLE, idx=0.
- **Latency:**
  - A word accepted at cycle n updates `regs_o` at n+1.
  - Strobes and `soft_reset_o` are high at n+1 only.
  - For readback or report commands, `jtag_wr`=1 and `jtag_d` are valid from n+1.
- **Soft reset:** 0xFF during a report cannot occur, because a receive only happens in IDLE. If it is received in IDLE, it also clears the shadow array and idx.
- **Reset mid-report:** the FSM returns to IDLE next cycle and `jtag_wr`=0. The host sees a truncated report.
- **Simultaneous events:** a write to register i and a readback of register i cannot occur in the same cycle. Readback returns the value committed before the readback command was accepted.
- **Wrap:** idx is 8 bits wide and never exceeds NUM_STATUS-1.

## Structure
- A shared package `jtag_cmd_pkg` holds:
  - the command constants CMD_RDBK_BASE=8'h80, CMD_STROBE_BASE=8'hF0, CMD_REPORT=8'hFE, CMD_RESET=8'hFF;
  - the FSM state enum {IDLE, RDBK, HDR, SEND}.
- One sub-module is natural: `jtag_report_seq`. It holds the shadow snapshot, idx and the HDR/SEND sequencing. Register decode stays in the top level.

## Test plan
- Bank write: with NUM_REGS=4 and REG_WIDTH=24, receive 0x02ABCDEF → `regs_o` register 2 = 0xABCDEF at n+1; all other registers unchanged.
- Readback: after the bank write, receive 0x82000000 → one word sent, 0x82ABCDEF, then wr=0 and the FSM is in IDLE.
- Report with snapshot: `status_i`={0x11111111, 0x22222222}, receive 0xFE000000, then change `status_i` → sent 0xFE020000, 0x22222222 (word 0 of the snapshot taken before the change), then 0x11111111, each on successive acks.
- Strobes and soft reset: receive 0xF3000000 → `strobe_o`=0x08 for exactly one cycle. Receive 0xFF000000 → `soft_reset_o` pulse and all registers = `RESET_VAL`.
- Out of range: receive 0x07123456 and 0x85000000 with NUM_REGS=4 → no register change and `jtag_wr` stays 0.
- Reset mid-report: assert `reset` after the header ack → next cycle `jtag_wr`=0, `jtag_req`=0 and the FSM is in IDLE; a new 0xFE afterwards produces a full report.
